apb_pwm_master: RTL and testbench

- APB master stage directly upstream of the APB PWM peripheral.
- Converts a simple valid/ready request channel from the core/bus fabric into APB SETUP/ACCESS transfers.
- Captures PRDATA and PSLVERR, and returns them on a valid/ready response channel.
- One outstanding transfer at a time.

---
 rtl/apb_pwm_master.sv | 126 ++++++++++++
 tb/tb_apb_pwm_master.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/apb_pwm_master.sv
// APB master for the PWM peripheral: valid/ready request -> APB SETUP/ACCESS -> valid/ready response.
// Optional ACCESS-phase timeout enabled by defining APB_PWM_MASTER_TIMEOUT_EN.
module apb_pwm_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  PSEL_o,
  output logic                  PENABLE_o,
  output logic                  PWRITE_o,
  output logic [ADDR_WIDTH-1:0] PADDR_o,
  output logic [DATA_WIDTH-1:0] PWDATA_o,
  input  logic [DATA_WIDTH-1:0] PRDATA_i,
  input  logic                  PREADY_i,
  input  logic                  PSLVERR_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q,   err_d;
  logic                    busy;
`ifdef APB_PWM_MASTER_TIMEOUT_EN
  logic [7:0]              wait_q,  wait_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef APB_PWM_MASTER_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef APB_PWM_MASTER_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef APB_PWM_MASTER_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          write_d = req_write_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          state_d = SETUP;
        end
      end
      SETUP: begin
`ifdef APB_PWM_MASTER_TIMEOUT_EN
        wait_d  = '0;
`endif
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completing PREADY wins over a timeout reached in the same cycle.
        if (PREADY_i) begin
          rdata_d = write_q ? '0 : PRDATA_i;
          err_d   = PSLVERR_i;
          state_d = RESP;
        end
`ifdef APB_PWM_MASTER_TIMEOUT_EN
        else if (wait_q == 8'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d  = wait_q + 8'd1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q == SETUP) || (state_q == ACCESS);
  assign req_ready_o = (state_q == IDLE);
  assign PSEL_o      = busy;
  assign PENABLE_o   = (state_q == ACCESS);
  assign PWRITE_o    = busy & write_q;
  assign PADDR_o     = busy ? addr_q  : '0;
  assign PWDATA_o    = busy ? wdata_q : '0;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = (state_q == RESP) ? rdata_q : '0;
  assign rsp_err_o   = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_apb_pwm_master.sv
// Bench for apb_pwm_master: vector table, hand sequences for reset/timeout, random transfers vs a model.
module tb_apb_pwm_master;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_write, rsp_valid, rsp_ready, rsp_err;
  logic [7:0]  req_addr, paddr;
  logic [31:0] req_wdata, rsp_rdata, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  apb_pwm_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .PSEL_o(psel), .PENABLE_o(penable), .PWRITE_o(pwrite), .PADDR_o(paddr), .PWDATA_o(pwdata),
    .PRDATA_i(prdata), .PREADY_i(pready), .PSLVERR_i(pslverr)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prd;
    logic        perr;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_acc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference: response and ACCESS length follow directly from the slave's wait count.
  function automatic void model(input logic wr, input logic [31:0] prd, input logic perr, input int waits,
                                output logic [31:0] rd, output logic err, output int acc);
`ifdef APB_PWM_MASTER_TIMEOUT_EN
    if (waits >= TO) begin
      rd = 32'h0; err = 1'b1; acc = TO;
      return;
    end
`endif
    rd  = wr ? 32'h0 : prd;
    err = perr;
    acc = waits + 1;
  endfunction

  // Starts at a negedge; returns at the negedge after the response handshake.
  task automatic run_txn(input vec_t v, input logic nxt_en, input vec_t nxt);
    int acc;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    chk("accept_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    chk("setup_psel_penable", {30'b0, psel, penable}, 32'd2);
    chk("setup_paddr", {24'b0, paddr}, {24'b0, v.addr});
    chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.wr});
    chk("setup_pwdata", pwdata, v.wdata);
    chk("setup_req_ready", {31'b0, req_ready}, 32'd0);
    req_valid = 1'b0; req_write = ~v.wr; req_addr = 8'($urandom); req_wdata = $urandom;
    rsp_ready = 1'($urandom);
    acc = 0;
    @(negedge clk);
    while (psel && penable && acc < 200) begin
      acc++;
      chk("access_paddr", {24'b0, paddr}, {24'b0, v.addr});
      chk("access_pwdata", pwdata, v.wdata);
      pready    = (acc == v.waits + 1);
      prdata    = pready ? v.prd : $urandom;
      pslverr   = pready ? v.perr : 1'($urandom);
      rsp_ready = 1'($urandom);
      @(negedge clk);
    end
    pready = 1'b0; pslverr = 1'b0; rsp_ready = 1'b0;
    chk("access_cycles", acc, v.exp_acc);
    for (int h = 0; h <= v.hold; h++) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_rdata", rsp_rdata, v.exp_rd);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, v.exp_err});
      chk("rsp_bus_idle", {30'b0, psel, penable}, 32'd0);
      chk("rsp_req_ready", {31'b0, req_ready}, 32'd0);
      if (nxt_en) begin
        req_valid = 1'b1; req_write = nxt.wr; req_addr = nxt.addr; req_wdata = nxt.wdata;
      end
      rsp_ready = (h == v.hold);
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk("post_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  vec_t tbl[6];
  vec_t none;

  initial begin
    logic [31:0] rd;
    logic        er;
    int          ac;
    vec_t        v;

    none = '{1'b0, 8'h0, 32'h0, 0, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1};
    //          wr    addr   wdata          waits prd            perr  hold exp_rd         exp_err exp_acc
    tbl[0] = '{1'b1, 8'h04, 32'h0000_00FF, 0, 32'hDEAD_BEEF, 1'b0, 0, 32'h0,         1'b0, 1};
    tbl[1] = '{1'b0, 8'h08, 32'h0,         3, 32'h1234_5678, 1'b0, 0, 32'h1234_5678, 1'b0, 4};
    tbl[2] = '{1'b0, 8'h10, 32'h0,         0, 32'h0000_A5A5, 1'b0, 5, 32'h0000_A5A5, 1'b0, 1};
    tbl[3] = '{1'b1, 8'h0C, 32'hCAFE_0001, 0, 32'hFFFF_FFFF, 1'b1, 0, 32'h0,         1'b1, 1};
    tbl[4] = '{1'b0, 8'h14, 32'h0,         0, 32'h0000_0055, 1'b0, 0, 32'h0000_0055, 1'b0, 1};
    tbl[5] = '{1'b0, 8'h00, 32'h0,         TO - 1, 32'h7777_0000, 1'b1, 1, 32'h7777_0000, 1'b1, TO};

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h0; req_wdata = 32'h0;
    rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_ctrl", {28'b0, rsp_valid, rsp_err, psel, penable}, 32'd0);
    chk("reset_pwrite", {31'b0, pwrite}, 32'd0);
    chk("reset_data", rsp_rdata | pwdata | {24'b0, paddr}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("idle_rsp_ready_ignored", {31'b0, rsp_valid}, 32'd0);
    rsp_ready = 1'b0;

    for (int i = 0; i < 6; i++)
      run_txn(tbl[i], (i == 2), (i == 2) ? tbl[3] : none);

    // Stuck slave: bounded by timeout when enabled, otherwise held indefinitely.
    v = '{1'b0, 8'h20, 32'h0, 1000, 32'h1111_2222, 1'b0, 0, 32'h0, 1'b0, 0};
`ifdef APB_PWM_MASTER_TIMEOUT_EN
    model(v.wr, v.prd, v.perr, v.waits, rd, er, ac);
    v.exp_rd = rd; v.exp_err = er; v.exp_acc = ac;
    run_txn(v, 1'b0, none);
`endif

    // Reset while ACCESS is waiting.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h18; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    pready = 1'b0;
`ifdef APB_PWM_MASTER_TIMEOUT_EN
    repeat (2) @(negedge clk);
`else
    repeat (101) @(negedge clk);
`endif
    chk("stall_access_held", {30'b0, psel, penable}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_bus", {30'b0, psel, penable}, 32'd0);
    chk("midreset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postreset_no_rsp", {29'b0, rsp_valid, psel, penable}, 32'd0);
    end
    rsp_ready = 1'b0;

    for (int n = 0; n < 40; n++) begin
      v.wr    = 1'($urandom);
      v.addr  = 8'($urandom);
      v.wdata = $urandom;
      v.waits = $urandom_range(0, 6);
      v.prd   = $urandom;
      v.perr  = 1'($urandom);
      v.hold  = $urandom_range(0, 3);
      model(v.wr, v.prd, v.perr, v.waits, rd, er, ac);
      v.exp_rd = rd; v.exp_err = er; v.exp_acc = ac;
      run_txn(v, 1'b0, none);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
